instr_prefetch: RTL and testbench

- Instruction prefetch queue between the instruction memory port and the fetch stage of the synchronous RV32I pipeline.
- Generates sequential word addresses and handles a variable-latency request/ack memory with one request outstanding.
- Buffers returned instructions with their PC in a small FIFO and presents them through a valid/ready interface.
- Flushes on a jump redirect from retire and stamps each instruction with a 4-bit epoch tag.

---
 rtl/instr_prefetch_if.sv | 30 +++
 rtl/instr_prefetch.sv | 99 +++++++++
 tb/tb_instr_prefetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// Prefetch bundle: instruction-memory request/ack port, retire redirect and fetch-side valid/ready head.
// master = prefetch queue, slave = memory + fetch/retire environment.
interface instr_prefetch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_data;
  logic          jump;
  logic [31:0]   jump_addr;
  logic          valid;
  logic [31:0]   instr;
  logic [31:0]   pc;
  logic [3:0]    tag;
  logic          ready;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, valid, instr, pc, tag, count,
    input  imem_ack, imem_data, jump, jump_addr, ready
  );

  modport slave (
    input  imem_req, imem_addr, valid, instr, pc, tag, count,
    output imem_ack, imem_data, jump, jump_addr, ready
  );
endinterface

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetch FIFO with epoch-tagged flush; ack in cycle N shows on valid in N+1.
// One request outstanding; stops requesting when next-cycle occupancy would reach DEPTH, holds head until ready.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          i_clk,
  input logic          i_rstn,
  instr_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  epoch;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc, hold_addr;
  logic [3:0]    epoch;
  logic          push, pop, room;
  logic [CW:0]   occ_nxt;
  logic          unused_jump_lsb;

  assign unused_jump_lsb = ^bus.jump_addr[1:0];

  assign push    = bus.imem_req & bus.imem_ack & (state == REQ) & ~bus.jump;
  assign pop     = bus.valid & bus.ready & ~bus.jump;
  assign occ_nxt = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign room    = occ_nxt < (CW+1)'(DEPTH);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.jump) begin
      // an unacked request must still be drained; its data belongs to the old stream
      state_nxt = ((state != IDLE) && !bus.imem_ack) ? DISCARD : REQ;
    end else begin
      case (state)
        IDLE:    if (room) state_nxt = REQ;
        REQ,
        DISCARD: if (bus.imem_ack) state_nxt = room ? REQ : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req  = (state != IDLE);
    bus.imem_addr = (state == DISCARD) ? hold_addr : fetch_pc;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      epoch     <= 4'd0;
    end else if (bus.jump) begin
      count    <= '0;
      rd_ptr   <= wr_ptr;
      fetch_pc <= {bus.jump_addr[31:2], 2'b00};
      epoch    <= epoch + 4'd1;
      if (state == REQ && !bus.imem_ack) hold_addr <= fetch_pc;
    end else begin
      count <= occ_nxt[CW-1:0];
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_data, epoch: epoch};
  end

  assign head      = mem[rd_ptr];
  assign bus.valid = (count != '0);
  assign bus.instr = bus.valid ? head.instr : 32'd0;
  assign bus.pc    = bus.valid ? head.pc    : 32'd0;
  assign bus.tag   = bus.valid ? head.epoch : 4'd0;
  assign bus.count = count;
endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized + directed bench for instr_prefetch; a stream-level model predicts queued entries and request addresses.
module tb_instr_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;

  instr_prefetch_if #(.DEPTH(DEPTH)) bus();

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_fetch, m_hold, prev_addr;
  logic [3:0]  m_epoch;
  logic        m_stale, prev_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the kept stream is sequential from the last redirect target; a request
  // outstanding across a redirect is stale and its data never enters the queue.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      exp_q.delete();
      m_fetch      = RESET_PC;
      m_hold       = RESET_PC;
      m_epoch      = 4'd0;
      m_stale      = 1'b0;
      prev_pending = 1'b0;
    end else begin
      chk("count", 32'(bus.count), 32'(exp_q.size()));
      chk("valid", 32'(bus.valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("head_pc", bus.pc, exp_q[0].pc);
        chk("head_instr", bus.instr, exp_q[0].instr);
        chk("head_tag", 32'(bus.tag), 32'(exp_q[0].tag));
      end
      if (bus.imem_req) chk("req_addr", bus.imem_addr, m_stale ? m_hold : m_fetch);
      if (prev_pending) begin
        chk("req_held", 32'(bus.imem_req), 32'd1);
        chk("addr_held", bus.imem_addr, prev_addr);
      end
      if (exp_q.size() >= DEPTH) chk("full_noreq", 32'(bus.imem_req), 32'd0);

      prev_pending = bus.imem_req & ~bus.imem_ack;
      prev_addr    = m_stale ? m_hold : m_fetch;
      if (bus.jump) begin
        exp_q.delete();
        if (bus.imem_req && !bus.imem_ack && !m_stale) begin
          m_stale = 1'b1;
          m_hold  = m_fetch;
        end else if (bus.imem_req && bus.imem_ack) begin
          m_stale = 1'b0;
        end
        m_fetch = {bus.jump_addr[31:2], 2'b00};
        m_epoch = m_epoch + 4'd1;
      end else begin
        if (bus.ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (bus.imem_req && bus.imem_ack) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            exp_q.push_back('{pc: m_fetch, instr: mem_word(m_fetch), tag: m_epoch});
            m_fetch = m_fetch + 32'd4;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_tag", 32'(bus.tag), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
  endtask

  // Leaves the bench at cycle 0 (first cycle out of reset), req expected low.
  task automatic do_reset();
    i_rstn = 1'b0;
    step(2);
    check_reset();
    i_rstn = 1'b1;
    chk("rel_req_low", 32'(bus.imem_req), 32'd0);
  endtask

  initial begin
    int n;
    bus.imem_ack  = 1'b0;
    bus.ready     = 1'b0;
    bus.jump      = 1'b0;
    bus.jump_addr = 32'd0;
    #12;
    check_reset();

    // zero-wait streaming, one instruction per cycle
    bus.imem_ack = 1'b1;
    bus.ready    = 1'b1;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("a_req", 32'(bus.imem_req), 32'd1);
      chk("a_addr", bus.imem_addr, 32'(4 * (i - 1)));
      if (i >= 2) begin
        chk("a_valid", 32'(bus.valid), 32'd1);
        chk("a_pc", bus.pc, 32'(4 * (i - 2)));
      end
    end

    // fill to full with consumer stalled
    bus.ready = 1'b0;
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.imem_req && bus.imem_ack) n++;
    end
    chk("b_nreq", 32'(n), 32'd4);
    chk("b_count", 32'(bus.count), 32'(DEPTH));
    chk("b_req", 32'(bus.imem_req), 32'd0);
    bus.ready = 1'b1;
    chk("b_head", bus.pc, 32'h0);
    step(1);
    bus.ready = 1'b0;
    chk("b_refill_req", 32'(bus.imem_req), 32'd1);
    chk("b_refill_addr", bus.imem_addr, 32'h10);
    step(3);

    // slow ack with redirect while waiting
    bus.imem_ack = 1'b0;
    bus.ready    = 1'b1;
    do_reset();
    step(1);
    chk("c_addr1", bus.imem_addr, 32'h0);
    step(1);
    bus.jump = 1'b1; bus.jump_addr = 32'h103;
    chk("c_addr2", bus.imem_addr, 32'h0);
    step(1);
    bus.jump = 1'b0;
    chk("c_addr3", bus.imem_addr, 32'h0);
    step(1);
    bus.imem_ack = 1'b1;
    chk("c_addr4", bus.imem_addr, 32'h0);
    step(1);
    chk("c_dropped", 32'(bus.valid), 32'd0);
    chk("c_new_addr", bus.imem_addr, 32'h100);
    step(1);
    chk("c_valid", 32'(bus.valid), 32'd1);
    chk("c_pc", bus.pc, 32'h100);
    chk("c_tag", 32'(bus.tag), 32'd1);
    step(3);

    // redirect coincident with an ack while two entries are queued
    bus.ready    = 1'b0;
    bus.imem_ack = 1'b1;
    do_reset();
    step(3);
    chk("d_count", 32'(bus.count), 32'd2);
    chk("d_addr", bus.imem_addr, 32'h8);
    bus.jump = 1'b1; bus.jump_addr = 32'h200;
    step(1);
    bus.jump = 1'b0;
    chk("d_flushed", 32'(bus.count), 32'd0);
    chk("d_req", 32'(bus.imem_req), 32'd1);
    chk("d_target", bus.imem_addr, 32'h200);
    bus.ready = 1'b1;
    step(4);

    // 16 back-to-back redirects (epoch wraps), last one at the top of memory
    bus.imem_ack = 1'b0;
    do_reset();
    step(1);
    for (int j = 0; j < 16; j++) begin
      bus.jump      = 1'b1;
      bus.jump_addr = (j == 15) ? 32'hFFFF_FFFC : $urandom;
      step(1);
    end
    bus.jump     = 1'b0;
    bus.imem_ack = 1'b1;
    step(1);
    chk("e_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk("e_addr_wrap", bus.imem_addr, 32'h0);
    chk("e_pc", bus.pc, 32'hFFFF_FFFC);
    chk("e_tag_wrap", 32'(bus.tag), 32'd0);
    step(3);

    // randomized traffic in segments of differing memory speed / consumer rate
    do_reset();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 750; i++) begin
        bus.imem_ack  = (s == 0) ? 1'b1 : ($urandom_range(0, 3) < s);
        bus.ready     = ($urandom_range(0, 9) < 3 + 2 * s);
        bus.jump      = ($urandom_range(0, 31) == 0);
        bus.jump_addr = $urandom;
        step(1);
      end
    end
    bus.jump = 1'b0;

    // async reset in the middle of a discard, then a late ack
    bus.imem_ack = 1'b0;
    bus.ready    = 1'b1;
    do_reset();
    step(1);
    bus.jump = 1'b1; bus.jump_addr = 32'h40;
    step(1);
    bus.jump = 1'b0;
    step(1);
    #2;
    i_rstn = 1'b0;
    #1;
    check_reset();
    bus.imem_ack = 1'b1;
    step(1);
    i_rstn = 1'b1;
    step(1);
    bus.imem_ack = 1'b0;
    chk("g_req", 32'(bus.imem_req), 32'd1);
    chk("g_addr", bus.imem_addr, RESET_PC);
    chk("g_ignored", 32'(bus.valid), 32'd0);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
